mips_run_ctrl: RTL and testbench

- Run/debug controller that sequences the TOP_MIPS pipeline.
- Owns the instruction-memory load path while i_loading is high.
- Starts execution, in continuous or single-step mode, by gating a global pipeline enable.
- Detects HALT (opcode 6'b111111) retiring in WB, then freezes the pipeline and raises o_finish.

---
 rtl/mips_run_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mips_run_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_ctrl.sv
// Run/debug controller for the TOP_MIPS pipeline: program load, flush, continuous or
// single-step run, HALT detection. Define MIPS_WATCHDOG_EN to add a cycle-limit timeout.
module mips_run_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_loading,
  input  logic                  i_load_valid,
  input  logic [DATA_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_instruccion,
  input  logic                  i_start,
  input  logic                  i_step_mode,
  input  logic                  i_step,
  input  logic                  i_halt_wb,
  output logic                  o_imem_we,
  output logic [DATA_WIDTH-1:0] o_imem_addr,
  output logic [DATA_WIDTH-1:0] o_imem_data,
  output logic                  o_pipe_en,
  output logic                  o_pipe_flush,
  output logic                  o_finish,
  output logic [2:0]            o_state,
  output logic [CNT_WIDTH-1:0]  o_cycle_count,
  output logic [CNT_WIDTH-1:0]  o_prog_len
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_FLUSH  = 3'd2,
    S_RUN    = 3'd3,
    S_STEP   = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  localparam logic [2:0] TIMEOUT_CODE = 3'd6;

  state_t                  state_reg, state_next;
  logic                    pipe_en_reg, pipe_en_next;
  logic                    flush_reg, flush_next;
  logic                    finish_reg, finish_next;
  logic                    step_mode_reg, step_mode_next;
  logic                    wdog_hit_reg, wdog_hit_next;
  logic                    we_reg, we_next;
  logic [DATA_WIDTH-1:0]   addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]   data_reg, data_next;
  logic [CNT_WIDTH-1:0]    count_reg, count_next;
  logic [CNT_WIDTH-1:0]    prog_len_reg, prog_len_next;
  logic                    start_d_reg, step_d_reg;

  logic                    start_edge, step_edge, halt_qual, wdog_expired;
  logic [CNT_WIDTH-1:0]    count_inc, addr_plus1;

  assign start_edge = i_start & ~start_d_reg;
  assign step_edge  = i_step & ~step_d_reg;
  // A HALT seen while the pipeline is frozen is stale and must not retire.
  assign halt_qual  = i_halt_wb & pipe_en_reg;
  assign count_inc  = (pipe_en_reg && (count_reg != '1)) ? count_reg + CNT_WIDTH'(1) : count_reg;
  assign addr_plus1 = CNT_WIDTH'(i_address) + CNT_WIDTH'(1);

`ifdef MIPS_WATCHDOG_EN
  assign wdog_expired = (count_inc >= CNT_WIDTH'(WDOG_LIMIT));
`else
  logic unused_wdog;
  assign wdog_expired = 1'b0;
  assign unused_wdog  = (WDOG_LIMIT == 0);
`endif

  always_comb begin
    state_next     = state_reg;
    pipe_en_next   = 1'b0;
    flush_next     = 1'b0;
    finish_next    = finish_reg;
    step_mode_next = step_mode_reg;
    wdog_hit_next  = wdog_hit_reg;
    we_next        = 1'b0;
    addr_next      = addr_reg;
    data_next      = data_reg;
    count_next     = count_inc;
    prog_len_next  = prog_len_reg;
    case (state_reg)
      S_IDLE, S_HALTED: begin
        if (i_loading) begin
          state_next    = S_LOAD;
          finish_next   = 1'b0;
          prog_len_next = '0;
          wdog_hit_next = 1'b0;
        end else if (start_edge) begin
          state_next     = S_FLUSH;
          flush_next     = 1'b1;
          finish_next    = 1'b0;
          count_next     = '0;
          step_mode_next = i_step_mode;
          wdog_hit_next  = 1'b0;
        end
      end
      S_LOAD: begin
        if (i_load_valid) begin
          we_next   = 1'b1;
          addr_next = i_address;
          data_next = i_instruccion;
          if (addr_plus1 > prog_len_reg) prog_len_next = addr_plus1;
        end
        if (!i_loading) state_next = S_IDLE;
      end
      S_FLUSH: begin
        state_next   = step_mode_reg ? S_STEP : S_RUN;
        pipe_en_next = ~step_mode_reg;
      end
      S_RUN, S_STEP: begin
        if (i_loading) begin
          state_next    = S_LOAD;
          prog_len_next = '0;
          wdog_hit_next = 1'b0;
        end else if (halt_qual) begin
          state_next  = S_HALTED;
          finish_next = 1'b1;
        end else if (wdog_expired) begin
          state_next    = S_HALTED;
          finish_next   = 1'b1;
          wdog_hit_next = 1'b1;
        end else begin
          // Step mode opens the pipeline for exactly one clock per step edge.
          pipe_en_next = (state_reg == S_RUN) ? 1'b1 : step_edge;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_reg     <= S_IDLE;
      pipe_en_reg   <= 1'b0;
      flush_reg     <= 1'b0;
      finish_reg    <= 1'b0;
      step_mode_reg <= 1'b0;
      wdog_hit_reg  <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      data_reg      <= '0;
      count_reg     <= '0;
      prog_len_reg  <= '0;
      start_d_reg   <= 1'b0;
      step_d_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pipe_en_reg   <= pipe_en_next;
      flush_reg     <= flush_next;
      finish_reg    <= finish_next;
      step_mode_reg <= step_mode_next;
      wdog_hit_reg  <= wdog_hit_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      count_reg     <= count_next;
      prog_len_reg  <= prog_len_next;
      start_d_reg   <= i_start;
      step_d_reg    <= i_step;
    end
  end

  assign o_imem_we     = we_reg;
  assign o_imem_addr   = addr_reg;
  assign o_imem_data   = data_reg;
  assign o_pipe_en     = pipe_en_reg;
  assign o_pipe_flush  = flush_reg;
  assign o_finish      = finish_reg;
  assign o_cycle_count = count_reg;
  assign o_prog_len    = prog_len_reg;
  assign o_state       = (state_reg == S_HALTED && wdog_hit_reg) ? TIMEOUT_CODE : state_reg;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Scoreboard bench for mips_run_ctrl: stimulus pushes expected writes, enable/flush
// cycles and halt results; a negedge monitor pops and compares as the DUT emits them.
module tb_mips_run_ctrl;
  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_loading = 0, i_load_valid = 0, i_start = 0, i_step_mode = 0, i_step = 0, i_halt_wb = 0;
  logic [31:0] i_address = 0, i_instruccion = 0;
  logic        o_imem_we, o_pipe_en, o_pipe_flush, o_finish;
  logic [31:0] o_imem_addr, o_imem_data, o_cycle_count, o_prog_len;
  logic [2:0]  o_state;

  mips_run_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(32), .WDOG_LIMIT(16)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_loading(i_loading), .i_load_valid(i_load_valid),
    .i_address(i_address), .i_instruccion(i_instruccion), .i_start(i_start),
    .i_step_mode(i_step_mode), .i_step(i_step), .i_halt_wb(i_halt_wb),
    .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data),
    .o_pipe_en(o_pipe_en), .o_pipe_flush(o_pipe_flush), .o_finish(o_finish),
    .o_state(o_state), .o_cycle_count(o_cycle_count), .o_prog_len(o_prog_len)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; int at; } wr_t;
  typedef struct { logic [31:0] count; logic [2:0] state; logic [31:0] plen; int at; } res_t;

  wr_t         wr_q[$];
  res_t        res_q[$];
  int          en_q[$];
  int          fl_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_prog_len = 0;
  logic [31:0] fixed_prog [3] = '{32'h00221821, 32'h00620821, 32'h20220FBD};

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end else
      $display("ok   %s = %0h (cycle %0d)", name, act, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every DUT output event must match the head of its queue.
  initial begin
    logic fin_d;
    wr_t  w;
    res_t r;
    int   t;
    fin_d = 1'b0;
    forever begin
      @(negedge clk);
      if (!i_reset) begin
        if (o_imem_we) begin
          if (wr_q.size() == 0) check("unexpected_write", 1, 0);
          else begin
            w = wr_q.pop_front();
            check("wr_addr", o_imem_addr, w.addr);
            check("wr_data", o_imem_data, w.data);
            check("wr_cycle", cyc, w.at);
          end
        end
        if (o_pipe_flush) begin
          if (fl_q.size() == 0) check("unexpected_flush", 1, 0);
          else begin t = fl_q.pop_front(); check("flush_cycle", cyc, t); end
        end
        if (o_pipe_en) begin
          if (en_q.size() == 0) check("unexpected_pipe_en", 1, 0);
          else begin t = en_q.pop_front(); check("pipe_en_cycle", cyc, t); end
        end
        if (o_finish && !fin_d) begin
          if (res_q.size() == 0) check("unexpected_finish", 1, 0);
          else begin
            r = res_q.pop_front();
            check("fin_count", o_cycle_count, r.count);
            check("fin_state", o_state, r.state);
            check("fin_prog_len", o_prog_len, r.plen);
            check("fin_cycle", cyc, r.at);
          end
        end
      end
      fin_d = o_finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(int n);
    repeat (n) tick();
  endtask

  task automatic do_load(int n, bit fixed);
    i_loading = 1;
    tick();
    m_prog_len = 0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] a, d;
      if (fixed) begin a = i; d = fixed_prog[i]; end
      else begin a = $urandom_range(0, 255); d = $urandom; end
      i_load_valid = 1; i_address = a; i_instruccion = d;
      wr_q.push_back('{a, d, cyc + 1});
      if (a + 1 > m_prog_len) m_prog_len = a + 1;
      if (!fixed && i == n - 1) i_loading = 0;
      tick();
      i_load_valid = 0; i_address = $urandom; i_instruccion = $urandom;
      if (!fixed && $urandom_range(0, 1) == 1) tick();
    end
    i_loading = 0;
    ticks(2);
    check("load_state_idle", o_state, 0);
    check("load_prog_len", o_prog_len, m_prog_len);
  endtask

  task automatic run_cont(int nen, bit abort);
    int k;
    i_step_mode = 0; i_start = 1;
    k = cyc;
    fl_q.push_back(k + 1);
    for (int j = 0; j < nen; j++) en_q.push_back(k + 2 + j);
    tick();
    i_start = 1'($urandom_range(0, 1));
    i_step_mode = 1'($urandom_range(0, 1));
    ticks(nen);
    if (!abort) begin
      i_halt_wb = 1;
      res_q.push_back('{nen, 3'd5, m_prog_len, k + 2 + nen});
      tick();
      i_halt_wb = 0;
      tick();
      check("halt_state", o_state, 5);
      check("halt_pipe_en", o_pipe_en, 0);
      check("halt_count", o_cycle_count, nen);
    end else begin
      i_loading = 1;
      tick();
      m_prog_len = 0;
      check("abort_state_load", o_state, 1);
      check("abort_pipe_en", o_pipe_en, 0);
      check("abort_count", o_cycle_count, nen);
      i_loading = 0;
      ticks(2);
      check("abort_idle", o_state, 0);
    end
    i_start = 0;
    tick();
  endtask

  task automatic run_step(int npulse, bit halt_last);
    int k, last_en, gap, hold;
    i_step_mode = 1; i_start = 1; i_step = 0;
    k = cyc;
    fl_q.push_back(k + 1);
    tick();
    i_start = 0; i_step_mode = 1'($urandom_range(0, 1));
    tick();
    last_en = -1;
    for (int p = 0; p < npulse; p++) begin
      gap = $urandom_range(1, 3);
      repeat (gap) begin
        if (cyc != last_en && $urandom_range(0, 1) == 1) i_halt_wb = 1;
        tick();
        i_halt_wb = 0;
      end
      hold = (p == 0) ? 1 : (p == 1) ? 5 : $urandom_range(1, 5);
      i_step = 1;
      last_en = cyc + 1;
      en_q.push_back(last_en);
      if (halt_last && p == npulse - 1) begin
        tick();
        i_halt_wb = 1;
        res_q.push_back('{npulse, 3'd5, m_prog_len, cyc + 1});
        tick();
        i_halt_wb = 0; i_step = 0;
      end else begin
        repeat (hold) begin
          if (cyc != last_en && $urandom_range(0, 1) == 1) i_halt_wb = 1;
          tick();
          i_halt_wb = 0;
        end
        i_step = 0;
      end
    end
    ticks(2);
    check("step_count", o_cycle_count, npulse);
    if (halt_last) check("step_halt_state", o_state, 5);
    else begin
      check("step_no_finish", o_finish, 0);
      check("step_state", o_state, 4);
      i_loading = 1;
      tick();
      m_prog_len = 0;
      i_loading = 0;
      ticks(2);
      check("step_abort_idle", o_state, 0);
    end
  endtask

  initial begin
    int k;
    ticks(3);
    check("rst_state", o_state, 0);
    check("rst_outputs", {o_imem_we, o_pipe_en, o_pipe_flush, o_finish}, 0);
    check("rst_counts", {o_cycle_count, o_prog_len}, 0);
    i_reset = 0;
    tick();

    i_halt_wb = 1; tick(); i_halt_wb = 0; tick();
    check("idle_halt_ignored", o_state, 0);

    do_load(3, 1'b1);
    run_cont(8, 1'b0);
    run_step(3, 1'b0);
    do_load($urandom_range(2, 6), 1'b0);
    run_step($urandom_range(2, 5), 1'b1);

    i_start = 1; i_loading = 1;
    tick();
    m_prog_len = 0;
    check("collide_load", o_state, 1);
    i_loading = 0;
    ticks(2);
    check("collide_idle", o_state, 0);
    check("collide_prog_len", o_prog_len, 0);
    i_start = 0;
    tick();

    for (int r = 0; r < 4; r++) begin
      do_load($urandom_range(1, 5), 1'b0);
      run_cont($urandom_range(1, 12), 1'b0);
    end
    run_cont(5, 1'b1);

    // Asynchronous reset during the fourth enabled cycle.
    i_start = 1; i_step_mode = 0;
    k = cyc;
    fl_q.push_back(k + 1);
    for (int j = 0; j < 4; j++) en_q.push_back(k + 2 + j);
    tick();
    i_start = 0;
    ticks(4);
    @(negedge clk);
    #1 i_reset = 1;
    #1;
    check("midrst_state", o_state, 0);
    check("midrst_outputs", {o_imem_we, o_pipe_en, o_pipe_flush, o_finish}, 0);
    check("midrst_counts", {o_cycle_count, o_prog_len}, 0);
    tick();
    i_reset = 0;
    m_prog_len = 0;
    tick();
    run_cont(6, 1'b0);

`ifdef MIPS_WATCHDOG_EN
    i_start = 1; i_step_mode = 0;
    k = cyc;
    fl_q.push_back(k + 1);
    for (int j = 0; j < 16; j++) en_q.push_back(k + 2 + j);
    res_q.push_back('{32'd16, 3'd6, m_prog_len, k + 18});
    tick();
    i_start = 0;
    ticks(30);
    check("wdog_state", o_state, 6);
    check("wdog_count", o_cycle_count, 16);
    check("wdog_finish", o_finish, 1);
    run_cont(4, 1'b0);
`else
    run_cont(40, 1'b1);
`endif

    ticks(3);
    check("wr_q_drained", wr_q.size(), 0);
    check("en_q_drained", en_q.size(), 0);
    check("fl_q_drained", fl_q.size(), 0);
    check("res_q_drained", res_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
